// File: rtl/hash_tx_serializer.sv
// rtl/hash_tx_serializer.sv - captures the final hash on out_en and streams it MSB byte first over a valid/ready link
module hash_tx_serializer #(
  parameter int HASH_BITS  = 512,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_p,
  input  logic                 out_en,
  input  logic [HASH_BITS-1:0] hash_in,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 err
);

  localparam int N  = HASH_BITS / 8;
  localparam int CW = $clog2(N);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SEND = 4'b0010,
    GAP  = 4'b0100,
    FIN  = 4'b1000
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [HASH_BITS-1:0] shreg;
  logic [CW-1:0]        byte_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 err_q;
  logic                 accept;
  logic                 last;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (byte_cnt == CW'(N - 1));
    case (state)
      IDLE: if (out_en) state_next = SEND;
      SEND: begin
        if (tx_ready) begin
          accept = 1'b1;
          if (last)                state_next = FIN;
          else if (GAP_CYCLES > 0) state_next = GAP;
        end
      end
      GAP:     if (gap_cnt == '0) state_next = SEND;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      // A pulse outside IDLE is reported but never disturbs the hash in flight.
      err_q <= out_en && (state != IDLE);
      if ((state == IDLE) && out_en) begin
        shreg    <= hash_in;
        byte_cnt <= '0;
      end else if (accept) begin
        shreg <= {shreg[HASH_BITS-9:0], 8'h00};
        if (!last) byte_cnt <= byte_cnt + CW'(1);
        if (GAP_CYCLES > 0) gap_cnt <= GW'(GAP_CYCLES - 1);
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  assign tx_valid = (state == SEND);
  assign tx_data  = shreg[HASH_BITS-1 -: 8];
  assign busy     = (state != IDLE);
  assign tx_done  = (state == FIN);
  assign err      = err_q;

endmodule
